// File: rtl/chirp_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : chirp_sweep_gen
//  Description : Linear chirp generator. Emits a stepped, saturating tuning
//                word for a downstream NCO. Defining CHIRP_TRIANGLE_EN adds a
//                descending leg, which turns the sawtooth into a triangle.
//  Revision    : 1.0 - initial release
// ============================================================================
module chirp_sweep_gen #(
    parameter int FTW_W   = 16,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         f_start,
    input  logic [7:0]         f_step,
    input  logic [7:0]         len,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               repeat_en,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_valid,
    output logic               busy,
    output logic               sweep_done
);

    localparam int PAD_W = FTW_W - 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1
`ifdef CHIRP_TRIANGLE_EN
        ,
        ST_DOWN  = 2'd2
`endif
    } state_t;

    state_t             state_q, state_d;
    logic               load_q, load_d;
    logic [7:0]         f_start_q, f_start_d;
    logic [7:0]         f_step_q, f_step_d;
    logic [7:0]         len_q, len_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               repeat_q, repeat_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic               ftw_valid_q, ftw_valid_d;
    logic               busy_q, busy_d;
    logic               sweep_done_q, sweep_done_d;

    logic               end_sweep;
    logic               go_idle;

    logic [FTW_W-1:0]   start_word;
    logic [FTW_W-1:0]   step_ext;
    logic [FTW_W:0]     sum_up;
    logic [FTW_W-1:0]   ftw_up;

    assign start_word = FTW_W'(f_start_q) << PAD_W;
    assign step_ext   = FTW_W'(f_step_q);
    assign sum_up     = {1'b0, ftw_q} + {1'b0, step_ext};
    assign ftw_up     = sum_up[FTW_W] ? {FTW_W{1'b1}} : sum_up[FTW_W-1:0];

`ifdef CHIRP_TRIANGLE_EN
    logic [FTW_W-1:0]   ftw_down;
    assign ftw_down = (ftw_q >= step_ext) ? (ftw_q - step_ext) : {FTW_W{1'b0}};
`endif

    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        f_start_d    = f_start_q;
        f_step_d     = f_step_q;
        len_d        = len_q;
        dwell_d      = dwell_q;
        repeat_d     = repeat_q;
        dwell_cnt_d  = dwell_cnt_q;
        step_cnt_d   = step_cnt_q;
        ftw_d        = ftw_q;
        ftw_valid_d  = ftw_valid_q;
        busy_d       = busy_q;
        sweep_done_d = 1'b0;
        end_sweep    = 1'b0;
        go_idle      = 1'b0;

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        f_start_d   = f_start;
                        f_step_d    = f_step;
                        len_d       = len;
                        dwell_d     = dwell;
                        repeat_d    = repeat_en;
                        dwell_cnt_d = '0;
                        step_cnt_d  = '0;
                        load_d      = 1'b1;
                        state_d     = ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        go_idle = 1'b1;
                    end else if (load_q) begin
                        // Parameters were captured last cycle; present the start word now.
                        load_d      = 1'b0;
                        ftw_d       = start_word;
                        ftw_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else if (dwell_cnt_q != dwell_q) begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end else if (step_cnt_q != len_q) begin
                        ftw_d       = ftw_up;
                        step_cnt_d  = step_cnt_q + 8'd1;
                        dwell_cnt_d = '0;
                    end else begin
`ifdef CHIRP_TRIANGLE_EN
                        if (len_q != 8'd0) begin
                            state_d     = ST_DOWN;
                            ftw_d       = ftw_down;
                            step_cnt_d  = 8'd1;
                            dwell_cnt_d = '0;
                        end else begin
                            end_sweep = 1'b1;
                        end
`else
                        end_sweep = 1'b1;
`endif
                    end
                end
`ifdef CHIRP_TRIANGLE_EN
                ST_DOWN: begin
                    if (abort) begin
                        go_idle = 1'b1;
                    end else if (dwell_cnt_q != dwell_q) begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end else if (step_cnt_q != len_q) begin
                        ftw_d       = ftw_down;
                        step_cnt_d  = step_cnt_q + 8'd1;
                        dwell_cnt_d = '0;
                    end else begin
                        end_sweep = 1'b1;
                    end
                end
`endif
                default: begin
                    go_idle = 1'b1;
                end
            endcase

            if (end_sweep) begin
                sweep_done_d = 1'b1;
                if (repeat_q) begin
                    // Reload in place so the output stream has no gap.
                    state_d     = ST_SWEEP;
                    ftw_d       = start_word;
                    step_cnt_d  = '0;
                    dwell_cnt_d = '0;
                end else begin
                    go_idle = 1'b1;
                end
            end

            if (go_idle) begin
                state_d     = ST_IDLE;
                load_d      = 1'b0;
                ftw_d       = '0;
                ftw_valid_d = 1'b0;
                busy_d      = 1'b0;
                dwell_cnt_d = '0;
                step_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            load_q       <= 1'b0;
            f_start_q    <= '0;
            f_step_q     <= '0;
            len_q        <= '0;
            dwell_q      <= '0;
            repeat_q     <= 1'b0;
            dwell_cnt_q  <= '0;
            step_cnt_q   <= '0;
            ftw_q        <= '0;
            ftw_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            f_start_q    <= f_start_d;
            f_step_q     <= f_step_d;
            len_q        <= len_d;
            dwell_q      <= dwell_d;
            repeat_q     <= repeat_d;
            dwell_cnt_q  <= dwell_cnt_d;
            step_cnt_q   <= step_cnt_d;
            ftw_q        <= ftw_d;
            ftw_valid_q  <= ftw_valid_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign ftw        = ftw_q;
    assign ftw_valid  = ftw_valid_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;

endmodule
`default_nettype wire

// File: tb/tb_chirp_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chirp_sweep_gen
//  Description : Directed self-checking bench for chirp_sweep_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chirp_sweep_gen;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic        abort;
    logic [7:0]  f_start;
    logic [7:0]  f_step;
    logic [7:0]  len;
    logic [3:0]  dwell;
    logic        repeat_en;
    logic [15:0] ftw;
    logic        ftw_valid;
    logic        busy;
    logic        sweep_done;

    int vectors    = 0;
    int miscompares = 0;

    chirp_sweep_gen #(.FTW_W(16), .DWELL_W(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .abort      (abort),
        .f_start    (f_start),
        .f_step     (f_step),
        .len        (len),
        .dwell      (dwell),
        .repeat_en  (repeat_en),
        .ftw        (ftw),
        .ftw_valid  (ftw_valid),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [7:0] fs, input logic [7:0] fst,
                               input logic [7:0] ln, input logic [3:0] dw,
                               input logic rep);
        f_start   = fs;
        f_step    = fst;
        len       = ln;
        dwell     = dw;
        repeat_en = rep;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({ftw_valid, busy, sweep_done, ftw} !== 19'd0) begin
            $display("FAIL reset: ftw=%h valid=%b busy=%b done=%b, expected all zero",
                     ftw, ftw_valid, busy, sweep_done);
            miscompares++;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done, ftw} !== 19'd0) begin
            $display("FAIL reset_idle: ftw=%h valid=%b busy=%b done=%b, expected all zero",
                     ftw, ftw_valid, busy, sweep_done);
            miscompares++;
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [8] = '{16'h1000, 16'h1000, 16'h1004, 16'h1004,
                                   16'h1008, 16'h1008, 16'h100C, 16'h100C};
        issue_start(8'h10, 8'h04, 8'd3, 4'd1, 1'b0);
        vectors++;
        if (ftw_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_latency: valid=%b busy=%b one edge after start, expected 0 0",
                     ftw_valid, busy);
            miscompares++;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if ({ftw_valid, busy, sweep_done, ftw} !== {3'b110, exp_w[i]}) begin
                $display("FAIL basic[%0d]: ftw=%h valid=%b busy=%b done=%b, expected ftw=%h valid=1 busy=1 done=0",
                         i, ftw, ftw_valid, busy, sweep_done, exp_w[i]);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done, ftw} !== {3'b001, 16'h0000}) begin
            $display("FAIL basic_end: ftw=%h valid=%b busy=%b done=%b, expected ftw=0 valid=0 busy=0 done=1",
                     ftw, ftw_valid, busy, sweep_done);
            miscompares++;
        end
        tick();
        vectors++;
        if (sweep_done !== 1'b0) begin
            $display("FAIL basic_done_pulse: done=%b, expected 0", sweep_done);
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_w [3] = '{16'hFF00, 16'hFFFF, 16'hFFFF};
        issue_start(8'hFF, 8'hFF, 8'd2, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({ftw_valid, busy, sweep_done, ftw} !== {3'b110, exp_w[i]}) begin
                $display("FAIL sat[%0d]: ftw=%h valid=%b busy=%b done=%b, expected ftw=%h valid=1 busy=1 done=0",
                         i, ftw, ftw_valid, busy, sweep_done, exp_w[i]);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done} !== 3'b001) begin
            $display("FAIL sat_end: valid=%b busy=%b done=%b, expected 0 0 1",
                     ftw_valid, busy, sweep_done);
            miscompares++;
        end
    endtask

    task automatic test_repeat_abort();
        logic [15:0] exp_w [5] = '{16'h1000, 16'h1004, 16'h1000, 16'h1004, 16'h1000};
        logic        exp_d [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        issue_start(8'h10, 8'h04, 8'd1, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({ftw_valid, busy, sweep_done, ftw} !== {2'b11, exp_d[i], exp_w[i]}) begin
                $display("FAIL repeat[%0d]: ftw=%h valid=%b busy=%b done=%b, expected ftw=%h valid=1 busy=1 done=%b",
                         i, ftw, ftw_valid, busy, sweep_done, exp_w[i], exp_d[i]);
                miscompares++;
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({ftw_valid, busy, sweep_done, ftw} !== 19'd0) begin
            $display("FAIL abort: ftw=%h valid=%b busy=%b done=%b, expected all zero",
                     ftw, ftw_valid, busy, sweep_done);
            miscompares++;
        end
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done, ftw} !== 19'd0) begin
            $display("FAIL abort_idle: ftw=%h valid=%b busy=%b done=%b, expected all zero",
                     ftw, ftw_valid, busy, sweep_done);
            miscompares++;
        end
    endtask

    task automatic test_len_zero();
        issue_start(8'h30, 8'h04, 8'd0, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({ftw_valid, busy, sweep_done, ftw} !== {3'b110, 16'h3000}) begin
                $display("FAIL len0[%0d]: ftw=%h valid=%b busy=%b done=%b, expected ftw=3000 valid=1 busy=1 done=0",
                         i, ftw, ftw_valid, busy, sweep_done);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done} !== 3'b001) begin
            $display("FAIL len0_end: valid=%b busy=%b done=%b, expected 0 0 1",
                     ftw_valid, busy, sweep_done);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        issue_start(8'h10, 8'h04, 8'd3, 4'd1, 1'b0);
        tick();
        tick();
        tick();
        vectors++;
        if (ftw !== 16'h1004) begin
            $display("FAIL rstmid_pre: ftw=%h, expected 1004", ftw);
            miscompares++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ftw_valid, busy, sweep_done, ftw} !== 19'd0) begin
            $display("FAIL rstmid: ftw=%h valid=%b busy=%b done=%b, expected all zero without an edge",
                     ftw, ftw_valid, busy, sweep_done);
            miscompares++;
        end
        rst_n     = 1'b1;
        f_start   = 8'h40;
        f_step    = 8'h01;
        len       = 8'd0;
        dwell     = 4'd0;
        repeat_en = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if ({ftw_valid, busy, ftw} !== {2'b11, 16'h4000}) begin
            $display("FAIL post_reset_start: ftw=%h valid=%b busy=%b, expected ftw=4000 valid=1 busy=1",
                     ftw, ftw_valid, busy);
            miscompares++;
        end
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done} !== 3'b001) begin
            $display("FAIL post_reset_end: valid=%b busy=%b done=%b, expected 0 0 1",
                     ftw_valid, busy, sweep_done);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_busy_ena();
        logic [15:0] exp_w [6] = '{16'h2000, 16'h2001, 16'h2001, 16'h2001, 16'h2001, 16'h2002};
        issue_start(8'h20, 8'h01, 8'd2, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            case (i)
                0: begin
                    start = 1'b1; f_start = 8'h55; f_step = 8'h10;
                    len = 8'd9; dwell = 4'd3; repeat_en = 1'b1;
                end
                1: begin start = 1'b0; ena = 1'b0; end
                4: ena = 1'b1;
                default: ;
            endcase
            vectors++;
            if ({ftw_valid, busy, sweep_done, ftw} !== {3'b110, exp_w[i]}) begin
                $display("FAIL busy_ena[%0d]: ftw=%h valid=%b busy=%b done=%b, expected ftw=%h valid=1 busy=1 done=0",
                         i, ftw, ftw_valid, busy, sweep_done, exp_w[i]);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done, ftw} !== {3'b001, 16'h0000}) begin
            $display("FAIL busy_ena_end: ftw=%h valid=%b busy=%b done=%b, expected ftw=0 valid=0 busy=0 done=1",
                     ftw, ftw_valid, busy, sweep_done);
            miscompares++;
        end
        repeat_en = 1'b0;
        tick();
    endtask

`ifdef CHIRP_TRIANGLE_EN
    task automatic test_triangle();
        logic [15:0] exp_w [5] = '{16'h1000, 16'h1004, 16'h1008, 16'h1004, 16'h1000};
        issue_start(8'h10, 8'h04, 8'd2, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({ftw_valid, busy, sweep_done, ftw} !== {3'b110, exp_w[i]}) begin
                $display("FAIL tri[%0d]: ftw=%h valid=%b busy=%b done=%b, expected ftw=%h valid=1 busy=1 done=0",
                         i, ftw, ftw_valid, busy, sweep_done, exp_w[i]);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if ({ftw_valid, busy, sweep_done} !== 3'b001) begin
            $display("FAIL tri_end: valid=%b busy=%b done=%b, expected 0 0 1",
                     ftw_valid, busy, sweep_done);
            miscompares++;
        end
        tick();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        f_start   = 8'h00;
        f_step    = 8'h00;
        len       = 8'd0;
        dwell     = 4'd0;
        repeat_en = 1'b0;

        test_reset();
`ifdef CHIRP_TRIANGLE_EN
        test_triangle();
        test_len_zero();
`else
        test_basic();
        test_saturation();
        test_repeat_abort();
        test_len_zero();
        test_reset_mid();
        test_busy_ena();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chirp_sweep_gen.md
CHIRP_SWEEP_GEN -- requirements
Module: chirp_sweep_gen

Interface
REQ-001 SHALL have parameter FTW_W, default 16, width of the tuning word sent to the NCO.
REQ-002 SHALL have parameter DWELL_W, default 4, width of the dwell (cycles-per-step) field.
REQ-003 SHALL have port clk  input  1  single design clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena  input  1  design-selected enable; low freezes all state.
REQ-006 SHALL have port start  input  1  sweep request, sampled each cycle.
REQ-007 SHALL have port abort  input  1  synchronous sweep cancel.
REQ-008 SHALL have port f_start  input  8  start tuning word, placed in the MSBs of ftw.
REQ-009 SHALL have port f_step  input  8  per-step increment, zero-extended to FTW_W.
REQ-010 SHALL have port len  input  8  number of increments per sweep.
REQ-011 SHALL have port dwell  input  DWELL_W  extra cycles per step; each step lasts dwell+1 cycles.
REQ-012 SHALL have port repeat_en  input  1  auto-restart after each sweep.
REQ-013 SHALL have port ftw  output  FTW_W  frequency tuning word to the downstream NCO.
REQ-014 SHALL have port ftw_valid  output  1  ftw is meaningful.
REQ-015 SHALL have port busy  output  1  sweep in progress.
REQ-016 SHALL have port sweep_done  output  1  one-cycle end-of-sweep pulse.

Function
REQ-017 SHALL implement FSM states IDLE and SWEEP (plus DOWN when CHIRP_TRIANGLE_EN is defined); all outputs registered.
REQ-018 IDLE: ftw=0, ftw_valid=0, busy=0; start=1 with ena=1 SHALL latch f_start, f_step, len, dwell and repeat_en, and enter SWEEP.
REQ-019 Latency: for start sampled at edge N, ftw={f_start,0...} with ftw_valid=1 and busy=1 SHALL be output after edge N+1.
REQ-020 SWEEP: dwell counter SHALL run 0..dwell; at dwell, if step count is below len then ftw+=f_step, step count increments and dwell counter clears; otherwise the sweep ends.
REQ-021 Ftw addition SHALL saturate at all-ones (no wrap-around).
REQ-022 End of sweep SHALL output sweep_done=1 for exactly one cycle, on the same edge as reload (repeat) or return to IDLE (ftw_valid=0, busy=0, ftw=0).
REQ-023 Repeat: on reload, ftw SHALL return to the latched start and counters SHALL clear with no gap cycle; ftw_valid stays 1.
REQ-024 len=0 SHALL hold the start word for dwell+1 cycles, then end the sweep.
REQ-025 A sweep with repeat off SHALL last (len+1)*(dwell+1) valid cycles.
REQ-026 start while busy SHALL be ignored; port changes while busy SHALL have no effect.
REQ-027 abort=1 with ena=1 SHALL move the FSM to IDLE on the next edge with no sweep_done; abort has priority over start and end of sweep.
REQ-028 ena=0 SHALL hold state, counters and all outputs (sweep_done forced 0) until ena returns.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, ftw=0, ftw_valid=0, busy=0, sweep_done=0 and counters=0, including during a sweep.
REQ-030 After release, the first start SHALL be honoured on the first edge where rst_n=1.

Configuration
REQ-031 Macro CHIRP_TRIANGLE_EN defined: after the last up step, the FSM SHALL enter DOWN and subtract f_step per step (floor 0) for len steps, and sweep_done SHALL follow the DOWN leg; total (2*len+1)*(dwell+1) cycles.
REQ-032 Macro CHIRP_TRIANGLE_EN undefined: sawtooth only; no DOWN state and no subtractor are synthesised.

Verification
REQ-033 f_start=0x10, f_step=0x04, len=3, dwell=1, repeat off -> ftw 0x1000,0x1000,0x1004,0x1004,0x1008,0x1008,0x100C,0x100C, then sweep_done=1, busy=0.
REQ-034 f_start=0xFF, f_step=0xFF, len=2, dwell=0 -> ftw 0xFF00, 0xFFFF, 0xFFFF (saturation).
REQ-035 repeat_en=1, f_start=0x10, f_step=0x04, len=1, dwell=0 -> 0x1000, 0x1004, then 0x1000 with sweep_done=1, repeating; abort -> ftw_valid=0 next cycle, no sweep_done.
REQ-036 rst_n=0 during the second step -> all outputs 0 with no clock edge; start while busy and ena=0 for 3 cycles -> sweep unchanged and stretched by exactly 3 cycles.
REQ-037 CHIRP_TRIANGLE_EN defined, f_start=0x10, f_step=0x04, len=2, dwell=0 -> 0x1000, 0x1004, 0x1008, 0x1004, 0x1000, then sweep_done=1.
